// File: rtl/tx_iq_shaper.sv
// TX sample stage: frames packets with zero padding, applies per-packet Q2 gain
// with round-half-up and saturation, and writes to the DAC FIFO under its not-full flag.
module tx_iq_shaper #(
  parameter int IQ_DATA_WIDTH = 16,
  parameter int GAIN_WIDTH    = 16,
  parameter int PAD_CNT_WIDTH = 8
) (
  input  logic                       acc_clk,
  input  logic                       acc_rst,
  input  logic                       tx_start,
  input  logic [PAD_CNT_WIDTH-1:0]   pre_pad_len,
  input  logic [PAD_CNT_WIDTH-1:0]   post_pad_len,
  input  logic [GAIN_WIDTH-1:0]      iq_gain,
  input  logic                       bypass_gain,
  input  logic [2*IQ_DATA_WIDTH-1:0] s_iq_data,
  input  logic                       s_iq_valid,
  input  logic                       s_iq_last,
  output logic                       s_iq_ready,
  output logic [2*IQ_DATA_WIDTH-1:0] data_to_acc,
  output logic                       data_valid_to_acc,
  input  logic                       fulln_from_acc,
  output logic                       busy,
  output logic                       tx_done,
  output logic [15:0]                sat_count
);

  localparam int W  = IQ_DATA_WIDTH;
  localparam int G  = GAIN_WIDTH;
  localparam int PW = W + G + 1;

  localparam logic signed [PW-1:0] RND  = {{(PW-G+2){1'b0}}, 1'b1, {(G-3){1'b0}}};
  localparam logic signed [PW-1:0] MAXV = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic [PAD_CNT_WIDTH-1:0] CNT_ZERO = {PAD_CNT_WIDTH{1'b0}};
  localparam logic [PAD_CNT_WIDTH-1:0] CNT_ONE  = {{(PAD_CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRE_PAD  = 3'd1,
    STREAM   = 3'd2,
    POST_PAD = 3'd3,
    FLUSH    = 3'd4
  } state_t;

  // Returns {clipped, value}: round half up, shift back to Q0, clamp to W bits.
  function automatic logic [W:0] round_sat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] r;
    r = (p + RND) >>> (G - 2);
    if (r > MAXV) begin
      round_sat = {1'b1, 1'b0, {(W-1){1'b1}}};
    end else if (r < MINV) begin
      round_sat = {1'b1, 1'b1, {(W-1){1'b0}}};
    end else begin
      round_sat = {1'b0, r[W-1:0]};
    end
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, inc};
    sat_add = sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  state_t                     state_r;
  logic [PAD_CNT_WIDTH-1:0]   cnt_r;
  logic [PAD_CNT_WIDTH-1:0]   post_len_r;
  logic [G-1:0]               gain_r;
  logic                       byp_r;
  logic                       tx_done_r;
  logic [15:0]                sat_r;

  logic                       s1_valid_r;
  logic                       s1_pad_r;
  logic                       s1_byp_r;
  logic [2*W-1:0]             s1_raw_r;
  logic signed [PW-1:0]       s1_pi_r;
  logic signed [PW-1:0]       s1_pq_r;
  logic                       s2_valid_r;
  logic [2*W-1:0]             s2_data_r;

  logic                       en_s;
  logic                       inj_valid_s;
  logic                       inj_pad_s;
  logic signed [W-1:0]        in_i_s;
  logic signed [W-1:0]        in_q_s;
  logic signed [G:0]          gain_sx_s;
  logic signed [PW-1:0]       prod_i_s;
  logic signed [PW-1:0]       prod_q_s;
  logic [W:0]                 rs_i_s;
  logic [W:0]                 rs_q_s;
  logic [2*W-1:0]             s2_next_s;
  logic [1:0]                 sat_inc_s;

  assign en_s              = fulln_from_acc;
  assign s_iq_ready        = (state_r == STREAM) && en_s;
  assign data_to_acc       = s2_data_r;
  assign data_valid_to_acc = s2_valid_r && fulln_from_acc;
  assign busy              = (state_r != IDLE);
  assign tx_done           = tx_done_r;
  assign sat_count         = sat_r;

  assign in_i_s    = s_iq_data[2*W-1:W];
  assign in_q_s    = s_iq_data[W-1:0];
  assign gain_sx_s = $signed({1'b0, gain_r});
  assign prod_i_s  = PW'(in_i_s) * PW'(gain_sx_s);
  assign prod_q_s  = PW'(in_q_s) * PW'(gain_sx_s);
  assign rs_i_s    = round_sat(s1_pi_r);
  assign rs_q_s    = round_sat(s1_pq_r);

  // Select what enters stage 1 this cycle: a zero pad word, an upstream sample, or nothing.
  always_comb begin
    inj_valid_s = 1'b0;
    inj_pad_s   = 1'b0;
    case (state_r)
      PRE_PAD, POST_PAD: begin
        inj_valid_s = 1'b1;
        inj_pad_s   = 1'b1;
      end
      STREAM: begin
        inj_valid_s = s_iq_valid;
        inj_pad_s   = 1'b0;
      end
      default: begin
        inj_valid_s = 1'b0;
        inj_pad_s   = 1'b0;
      end
    endcase
  end

  // Stage-2 word and clip count; pads are forced to exact zero and never count.
  always_comb begin
    s2_next_s = {(2*W){1'b0}};
    sat_inc_s = 2'd0;
    if (s1_pad_r) begin
      s2_next_s = {(2*W){1'b0}};
    end else if (s1_byp_r) begin
      s2_next_s = s1_raw_r;
    end else begin
      s2_next_s = {rs_i_s[W-1:0], rs_q_s[W-1:0]};
      if (s1_valid_r) begin
        sat_inc_s = {1'b0, rs_i_s[W]} + {1'b0, rs_q_s[W]};
      end else begin
        sat_inc_s = 2'd0;
      end
    end
  end

  // Two-stage datapath; everything holds while the FIFO reports full.
  always_ff @(posedge acc_clk) begin
    if (acc_rst) begin
      s1_valid_r <= 1'b0;
      s1_pad_r   <= 1'b0;
      s1_byp_r   <= 1'b0;
      s1_raw_r   <= {(2*W){1'b0}};
      s1_pi_r    <= {PW{1'b0}};
      s1_pq_r    <= {PW{1'b0}};
      s2_valid_r <= 1'b0;
      s2_data_r  <= {(2*W){1'b0}};
    end else if (en_s) begin
      s1_valid_r <= inj_valid_s;
      s1_pad_r   <= inj_pad_s;
      s1_byp_r   <= byp_r;
      s1_raw_r   <= inj_pad_s ? {(2*W){1'b0}} : s_iq_data;
      s1_pi_r    <= prod_i_s;
      s1_pq_r    <= prod_q_s;
      s2_valid_r <= s1_valid_r;
      s2_data_r  <= s2_next_s;
    end
  end

  // Per-packet saturation counter, cleared by an accepted start.
  always_ff @(posedge acc_clk) begin
    if (acc_rst) begin
      sat_r <= 16'd0;
    end else if ((state_r == IDLE) && tx_start) begin
      sat_r <= 16'd0;
    end else if (en_s) begin
      sat_r <= sat_add(sat_r, sat_inc_s);
    end
  end

  // Packet sequencer; a start pulse is only honoured from IDLE.
  always_ff @(posedge acc_clk) begin
    if (acc_rst) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      post_len_r <= CNT_ZERO;
      gain_r     <= {G{1'b0}};
      byp_r      <= 1'b0;
      tx_done_r  <= 1'b0;
    end else begin
      tx_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (tx_start) begin
            post_len_r <= post_pad_len;
            gain_r     <= iq_gain;
            byp_r      <= bypass_gain;
            cnt_r      <= pre_pad_len;
            state_r    <= (pre_pad_len == CNT_ZERO) ? STREAM : PRE_PAD;
          end
        end
        PRE_PAD: begin
          if (en_s) begin
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
              state_r <= STREAM;
            end
          end
        end
        STREAM: begin
          if (en_s && s_iq_valid && s_iq_last) begin
            cnt_r   <= post_len_r;
            state_r <= (post_len_r == CNT_ZERO) ? FLUSH : POST_PAD;
          end
        end
        POST_PAD: begin
          if (en_s) begin
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
              state_r <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (en_s && !s1_valid_r && !s2_valid_r) begin
            tx_done_r <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_iq_shaper.sv
// Directed bench for tx_iq_shaper: table of single-sample gain vectors plus
// hand-written sequences for padding, back-pressure, ignored start and reset abort.
module tb_tx_iq_shaper;

  logic        acc_clk = 1'b0;
  logic        acc_rst;
  logic        tx_start;
  logic [7:0]  pre_pad_len;
  logic [7:0]  post_pad_len;
  logic [15:0] iq_gain;
  logic        bypass_gain;
  logic [31:0] s_iq_data;
  logic        s_iq_valid;
  logic        s_iq_last;
  logic        s_iq_ready;
  logic [31:0] data_to_acc;
  logic        data_valid_to_acc;
  logic        fulln_from_acc;
  logic        busy;
  logic        tx_done;
  logic [15:0] sat_count;

  tx_iq_shaper dut (
    .acc_clk(acc_clk), .acc_rst(acc_rst), .tx_start(tx_start),
    .pre_pad_len(pre_pad_len), .post_pad_len(post_pad_len), .iq_gain(iq_gain),
    .bypass_gain(bypass_gain), .s_iq_data(s_iq_data), .s_iq_valid(s_iq_valid),
    .s_iq_last(s_iq_last), .s_iq_ready(s_iq_ready), .data_to_acc(data_to_acc),
    .data_valid_to_acc(data_valid_to_acc), .fulln_from_acc(fulln_from_acc),
    .busy(busy), .tx_done(tx_done), .sat_count(sat_count)
  );

  always #5 acc_clk = ~acc_clk;

  typedef struct {
    logic [15:0] gain;
    logic        byp;
    logic [31:0] din;
    logic [31:0] dout;
    logic [15:0] sat;
  } vec_t;

  vec_t        tbl [11];
  logic [31:0] src   [16];
  logic [31:0] exp_w [16];
  logic [31:0] wr_q [$];
  int checks = 0, failures = 0;
  int cyc_n = 0, done_cnt = 0, last_wr_cyc = 0, done_cyc = 0;

  // Record every FIFO write and every tx_done pulse, sampled mid-cycle.
  always @(negedge acc_clk) begin
    cyc_n++;
    if (data_valid_to_acc) begin
      wr_q.push_back(data_to_acc);
      last_wr_cyc = cyc_n;
    end
    if (tx_done) begin
      done_cnt++;
      done_cyc = cyc_n;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge acc_clk);
    #2;
  endtask

  task automatic send_packet(input string name, input int pre, input int post,
                             input logic [15:0] gain, input logic byp, input int n,
                             input int stall_at, input int stall_len, input bit extra_start);
    int d0, idx, st, busy_bad, stall_bad, cyc;
    wr_q.delete();
    d0 = done_cnt; idx = 0; st = 0; busy_bad = 0; stall_bad = 0;
    tick();
    pre_pad_len = 8'(pre); post_pad_len = 8'(post); iq_gain = gain; bypass_gain = byp;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    for (cyc = 0; cyc < 400 && done_cnt == d0; cyc++) begin
      tx_start = (extra_start && cyc == 1) ? 1'b1 : 1'b0;
      if (stall_len > 0 && idx == stall_at && st < stall_len) begin
        fulln_from_acc = 1'b0;
        st++;
      end else begin
        fulln_from_acc = 1'b1;
      end
      s_iq_valid = (idx < n);
      s_iq_data  = (idx < n) ? src[idx] : 32'h0000_0000;
      s_iq_last  = (idx == n - 1);
      #1;
      if (!fulln_from_acc && (s_iq_ready || data_valid_to_acc)) stall_bad++;
      if (!busy && !tx_done) busy_bad++;
      if (s_iq_valid && s_iq_ready) idx++;
      tick();
    end
    tx_start = 1'b0; fulln_from_acc = 1'b1; s_iq_valid = 1'b0; s_iq_last = 1'b0;
    chk({name, " done_in_time"}, 32'(done_cnt - d0), 32'd1);
    chk({name, " done_gap"}, 32'(done_cyc - last_wr_cyc), 32'd2);
    repeat (4) tick();
    chk({name, " done_once"}, 32'(done_cnt - d0), 32'd1);
    chk({name, " busy_after"}, {31'd0, busy}, 32'd0);
    chk({name, " busy_during"}, 32'(busy_bad), 32'd0);
    if (stall_len > 0) chk({name, " stall_quiet"}, 32'(stall_bad), 32'd0);
    chk({name, " write_count"}, 32'(wr_q.size()), 32'(pre + n + post));
    for (int k = 0; k < pre + n + post && k < wr_q.size(); k++) begin
      if (k < pre || k >= pre + n) chk($sformatf("%s word%0d", name, k), wr_q[k], 32'h0000_0000);
      else                         chk($sformatf("%s word%0d", name, k), wr_q[k], exp_w[k - pre]);
    end
  endtask

  initial begin
    // gain, bypass, input {I,Q}, expected {I,Q}, expected sat_count
    tbl[0]  = '{16'h4000, 1'b0, 32'h1234_FEDC, 32'h1234_FEDC, 16'd0};
    tbl[1]  = '{16'h8000, 1'b0, 32'h5000_C000, 32'h7FFF_8000, 16'd1};
    tbl[2]  = '{16'h8000, 1'b0, 32'h5000_B000, 32'h7FFF_8000, 16'd2};
    tbl[3]  = '{16'h2000, 1'b0, 32'h0003_FFFD, 32'h0002_FFFF, 16'd0};
    tbl[4]  = '{16'h2000, 1'b1, 32'h0003_FFFD, 32'h0003_FFFD, 16'd0};
    tbl[5]  = '{16'hFFFF, 1'b1, 32'h7FFF_8000, 32'h7FFF_8000, 16'd0};
    tbl[6]  = '{16'hFFFF, 1'b0, 32'h0001_FFFF, 32'h0004_FFFC, 16'd0};
    tbl[7]  = '{16'h0000, 1'b0, 32'h7FFF_8000, 32'h0000_0000, 16'd0};
    tbl[8]  = '{16'h6000, 1'b0, 32'h0001_0003, 32'h0002_0005, 16'd0};
    tbl[9]  = '{16'h4000, 1'b0, 32'h8000_7FFF, 32'h8000_7FFF, 16'd0};
    tbl[10] = '{16'h4001, 1'b0, 32'h7FFF_8000, 32'h7FFF_8000, 16'd2};

    acc_rst = 1'b1; tx_start = 1'b0; pre_pad_len = 8'd0; post_pad_len = 8'd0;
    iq_gain = 16'h0000; bypass_gain = 1'b0; s_iq_data = 32'h0000_0000;
    s_iq_valid = 1'b0; s_iq_last = 1'b0; fulln_from_acc = 1'b1;
    repeat (3) tick();
    acc_rst = 1'b0;
    #1;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst valid", {31'd0, data_valid_to_acc}, 32'd0);
    chk("rst ready", {31'd0, s_iq_ready}, 32'd0);
    chk("rst data", data_to_acc, 32'h0000_0000);
    chk("rst done", {31'd0, tx_done}, 32'd0);
    chk("rst sat", {16'd0, sat_count}, 32'd0);

    for (int v = 0; v < 11; v++) begin
      src[0] = tbl[v].din; exp_w[0] = tbl[v].dout;
      send_packet($sformatf("vec%0d", v), 0, 0, tbl[v].gain, tbl[v].byp, 1, 0, 0, 1'b0);
      chk($sformatf("vec%0d sat", v), {16'd0, sat_count}, {16'd0, tbl[v].sat});
    end

    // Padded unity-gain packet
    src[0] = 32'h0001_0002; src[1] = 32'h1111_EEEE; src[2] = 32'h7FFF_8000; src[3] = 32'hABCD_1234;
    for (int k = 0; k < 4; k++) exp_w[k] = src[k];
    send_packet("t1", 2, 3, 16'h4000, 1'b0, 4, 0, 0, 1'b0);
    chk("t1 sat", {16'd0, sat_count}, 32'd0);

    // Back-pressure held for 5 cycles in mid-stream
    for (int k = 0; k < 6; k++) begin
      src[k] = 32'h0100_0200 + 32'(k) * 32'h0001_0001;
      exp_w[k] = src[k];
    end
    send_packet("t4", 1, 1, 16'h4000, 1'b0, 6, 2, 5, 1'b0);

    // Single-sample packet with a start pulse issued while busy
    src[0] = 32'h2222_DDDD; exp_w[0] = 32'h2222_DDDD;
    send_packet("t5", 0, 0, 16'h4000, 1'b0, 1, 0, 0, 1'b1);

    // Reset asserted while pre-padding
    tick();
    pre_pad_len = 8'd10; post_pad_len = 8'd1; iq_gain = 16'h4000; bypass_gain = 1'b0;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    repeat (3) tick();
    acc_rst = 1'b1;
    tick();
    acc_rst = 1'b0;
    #1;
    chk("t6 busy", {31'd0, busy}, 32'd0);
    chk("t6 valid", {31'd0, data_valid_to_acc}, 32'd0);
    chk("t6 ready", {31'd0, s_iq_ready}, 32'd0);
    chk("t6 data", data_to_acc, 32'h0000_0000);
    chk("t6 done", {31'd0, tx_done}, 32'd0);
    begin
      int d0;
      wr_q.delete();
      d0 = done_cnt;
      repeat (20) tick();
      chk("t6 no_writes", 32'(wr_q.size()), 32'd0);
      chk("t6 no_done", 32'(done_cnt - d0), 32'd0);
    end
    src[0] = 32'h0010_0020; src[1] = 32'hFFF0_FFE0;
    exp_w[0] = 32'h0008_0010; exp_w[1] = 32'hFFF8_FFF0;
    send_packet("t6_fresh", 1, 1, 16'h2000, 1'b0, 2, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
